// File: rtl/result_view_ctrl.sv
// result_view_ctrl: replays the sorted array on the LED bus after the sort
// program finishes. Each element is fetched over the shared data-memory
// request/grant port and held until the dwell time expires (auto mode) or
// the step button is pressed (manual mode).
module result_view_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int BASE_ADDR    = 0,
    parameter int WORD_BYTES   = 4,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] count,
    input  logic                  autoMode,
    input  logic                  stepBtn,
    output logic                  memReq,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic                  memGrant,
    input  logic [DATA_WIDTH-1:0] memData,
    output logic [DATA_WIDTH-1:0] ledData,
    output logic                  ledValid,
    output logic [15:0]           index,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_SHOW = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(WORD_BYTES);
    localparam logic [31:0]           DWELL_LOAD = 32'(DWELL_CYCLES - 1);

    logic [2:0]            state;
    logic [15:0]           cnt;
    logic [15:0]           idx;
    logic [31:0]           dwell;
    logic                  step_q;

    logic                  step_edge;
    logic                  advance;
    logic                  last_elem;
    logic [15:0]           count_sat;
    logic [15:0]           idx_next;
    logic [ADDR_WIDTH-1:0] next_addr;

    // Advance decision, saturated count and next fetch address.
    always_comb begin
        step_edge = stepBtn & ~step_q;
        advance   = autoMode ? (dwell == '0) : step_edge;
        idx_next  = idx + 16'd1;
        last_elem = (({1'b0, idx} + 17'd1) == {1'b0, cnt});
        count_sat = (count > DATA_WIDTH'(16'hFFFF)) ? 16'hFFFF : count[15:0];
        next_addr = BASE + ADDR_WIDTH'(idx_next) * STRIDE;
    end

    // Sequencer: fetch, show, advance; step edges outside SHOW are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            dwell    <= '0;
            step_q   <= 1'b0;
            memReq   <= 1'b0;
            memAddr  <= '0;
            ledData  <= '0;
            ledValid <= 1'b0;
            index    <= '0;
        end else begin
            step_q <= stepBtn;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (count == '0) begin
                            state <= S_DONE;
                        end else begin
                            cnt     <= count_sat;
                            idx     <= '0;
                            memReq  <= 1'b1;
                            memAddr <= BASE;
                            state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (memGrant) begin
                        memReq <= 1'b0;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    ledData  <= memData;
                    ledValid <= 1'b1;
                    index    <= idx;
                    dwell    <= DWELL_LOAD;
                    state    <= S_SHOW;
                end
                S_SHOW: begin
                    if (advance) begin
                        if (last_elem) begin
                            state <= S_DONE;
                        end else begin
                            idx     <= idx_next;
                            memReq  <= 1'b1;
                            memAddr <= next_addr;
                            state   <= S_REQ;
                        end
                    end else if (autoMode) begin
                        dwell <= dwell - 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_REQ) || (state == S_WAIT) || (state == S_SHOW);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_result_view_ctrl.sv
// Self-checking bench for result_view_ctrl: directed scenarios plus random
// runs, compared every cycle against a behavioural model of the sequence.
module tb_result_view_ctrl;

    localparam int DWELL = 4;
    localparam logic [31:0] BASE = 32'h100;

    logic        clk = 1'b0;
    logic        rst, start, autoMode, stepBtn, memGrant;
    logic [31:0] count, memData;
    logic        memReq, ledValid, busy, done;
    logic [31:0] memAddr, ledData;
    logic [15:0] index;

    result_view_ctrl #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .BASE_ADDR   (32'h100),
        .WORD_BYTES  (4),
        .DWELL_CYCLES(DWELL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .count(count),
        .autoMode(autoMode), .stepBtn(stepBtn),
        .memReq(memReq), .memAddr(memAddr), .memGrant(memGrant), .memData(memData),
        .ledData(ledData), .ledValid(ledValid), .index(index),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:63];

    // behavioural model of what the outputs must be
    bit          e_req, e_valid, e_done;
    logic [31:0] e_addr, e_led;
    int          e_index;
    bit          m_capture, m_showing, m_btn;
    int          m_cnt, m_next, m_left;

    // memory/arbiter stub state
    bit          req_seen, noise, gdelay_rand, btn_rand;
    logic [31:0] addr_seen;
    int          gdelay, gwait;

    // observation helpers for literal checks
    int          cyc, hold_ctr, req_len, addr_moves, fall_cyc, cap_cyc;
    bit          p_valid, p_req, p_done;
    logic [15:0] p_index;
    logic [31:0] p_led, p_addr;
    logic [31:0] addrs[$];
    int          holds[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_idle();
        return !(e_req || m_capture || m_showing);
    endfunction

    // Model one rising edge from the inputs presented to it.
    task automatic model_edge();
        bit rise, adv;
        rise = stepBtn && !m_btn;
        if (rst) begin
            e_req = 0; e_addr = '0; e_led = '0; e_valid = 0; e_index = 0; e_done = 0;
            m_capture = 0; m_showing = 0; m_btn = 0; m_cnt = 0; m_next = 0; m_left = 0;
            return;
        end
        m_btn = stepBtn;
        if (e_req) begin
            if (memGrant) begin e_req = 0; m_capture = 1; end
        end else if (m_capture) begin
            m_capture = 0; m_showing = 1;
            e_led = mem[m_next % 64]; e_valid = 1; e_index = m_next; m_left = DWELL;
        end else if (m_showing) begin
            adv = autoMode ? (m_left == 1) : rise;
            if (!adv) begin
                if (autoMode) m_left--;
            end else begin
                m_showing = 0;
                if (m_next + 1 == m_cnt) e_done = 1;
                else begin
                    m_next++;
                    e_req = 1;
                    e_addr = BASE + 32'(m_next * 4);
                end
            end
        end else if (start) begin
            if (count == 0) e_done = 1;
            else begin
                m_cnt = (count > 65535) ? 65535 : int'(count);
                m_next = 0; e_req = 1; e_addr = BASE; e_done = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("memReq",   32'(memReq),   32'(e_req));
        chk("memAddr",  memAddr,       e_addr);
        chk("ledData",  ledData,       e_led);
        chk("ledValid", 32'(ledValid), 32'(e_valid));
        chk("index",    32'(index),    32'(e_index));
        chk("busy",     32'(busy),     32'(!model_idle()));
        chk("done",     32'(done),     32'(e_done));
    endtask

    task automatic tick();
        bit taken;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        taken = memGrant && req_seen;
        compare_all();
        if ((ledValid && !p_valid) || (index != p_index) || (ledData != p_led)) begin
            hold_ctr = 0; cap_cyc = cyc;
        end else if (hold_ctr >= 0) hold_ctr++;
        if (memReq && !p_req) begin
            addrs.push_back(memAddr);
            if (hold_ctr >= 0) begin holds.push_back(hold_ctr); hold_ctr = -1; end
        end
        if (done && !p_done && hold_ctr >= 0) begin holds.push_back(hold_ctr); hold_ctr = -1; end
        if (memReq) begin
            req_len++;
            if (p_req && memAddr != p_addr) addr_moves++;
        end
        if (!memReq && p_req) fall_cyc = cyc;
        p_valid = ledValid; p_index = index; p_led = ledData;
        p_req = memReq; p_done = done; p_addr = memAddr;
        memData = taken ? mem[((addr_seen - BASE) >> 2) & 32'd63] : $urandom;
        if (memReq && !req_seen) gwait = gdelay_rand ? int'($urandom_range(0, 3)) : gdelay;
        if (memReq) begin
            memGrant = (gwait == 0);
            if (gwait != 0) gwait--;
        end else memGrant = noise && ($urandom_range(0, 3) == 0);
        req_seen = memReq; addr_seen = memAddr;
        if (btn_rand && !autoMode) stepBtn = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_obs();
        addrs.delete(); holds.delete();
        hold_ctr = -1; req_len = 0; addr_moves = 0;
    endtask

    task automatic run_until_idle(input string nm, input int limit);
        int n = 0;
        do begin tick(); n++; end while (!model_idle() && n < limit);
        if (!model_idle()) begin
            vectors++; miscompares++;
            $display("FAIL %s: still busy after %0d cycles, required idle", nm, limit);
        end
    endtask

    // which: 0 = showing, 1 = capture pending, 2 = last dwell cycle
    task automatic wait_phase(input string nm, input int which, input int limit);
        int n = 0;
        while (n < limit && !((which == 0 && m_showing) || (which == 1 && m_capture) ||
                              (which == 2 && m_showing && m_left == 1))) begin
            tick(); n++;
        end
        if (n >= limit) begin
            vectors++; miscompares++;
            $display("FAIL %s: phase %0d not reached in %0d cycles", nm, which, limit);
        end
    endtask

    initial begin
        rst = 1; start = 0; count = '0; autoMode = 1; stepBtn = 0; memGrant = 0; memData = '0;
        noise = 0; gdelay_rand = 0; btn_rand = 0; gdelay = 0; gwait = 0; cyc = 0;
        req_seen = 0; addr_seen = '0;
        p_valid = 0; p_req = 0; p_done = 0; p_index = '0; p_led = '0; p_addr = '0;
        e_req = 0; e_addr = '0; e_led = '0; e_valid = 0; e_index = 0; e_done = 0;
        m_capture = 0; m_showing = 0; m_btn = 0; m_cnt = 0; m_next = 0; m_left = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        clear_obs();
        tick(); tick();
        chk("reset_memReq", 32'(memReq), 32'd0);
        chk("reset_ledValid", 32'(ledValid), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 0;
        tick();

        // count = 0: straight to DONE, no fetch
        start = 1; count = 0; tick(); start = 0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_memReq", 32'(memReq), 32'd0);
        chk("zero_ledValid", 32'(ledValid), 32'd0);
        repeat (3) tick();

        // auto sequence, grant one cycle after each request
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        clear_obs(); gdelay = 1; autoMode = 1;
        start = 1; count = 3; tick(); start = 0;
        run_until_idle("auto_seq", 200);
        chk("auto_nreq", 32'(addrs.size()), 32'd3);
        chk("auto_nhold", 32'(holds.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("auto_addr", (i < addrs.size()) ? addrs[i] : 32'hDEAD, 32'h100 + 32'(4 * i));
            chk("auto_hold", (i < holds.size()) ? 32'(holds[i]) : 32'hDEAD, 32'd4);
        end
        chk("auto_done", 32'(done), 32'd1);
        chk("auto_last", ledData, 32'h33);

        // delayed grant
        mem[0] = 32'hCAFE_0001;
        clear_obs(); gdelay = 5;
        start = 1; count = 1; tick(); start = 0;
        run_until_idle("delay_grant", 200);
        chk("delay_reqlen", 32'(req_len), 32'd6);
        chk("delay_addrmove", 32'(addr_moves), 32'd0);
        chk("delay_nfetch", 32'(addrs.size()), 32'd1);
        chk("delay_latency", 32'(cap_cyc - fall_cyc), 32'd1);
        chk("delay_led", ledData, 32'hCAFE_0001);

        // start while busy is ignored
        mem[0] = 32'hAAAA_0000; mem[1] = 32'hBBBB_0001;
        clear_obs(); gdelay = 0;
        start = 1; count = 2; tick(); start = 0; tick();
        start = 1; count = 5; repeat (3) tick(); start = 0;
        run_until_idle("busy_start", 200);
        chk("busy_start_n", 32'(addrs.size()), 32'd2);
        chk("busy_start_idx", 32'(index), 32'd1);

        // manual stepping
        mem[0] = 32'hA5A5_0001; mem[1] = 32'hA5A5_0002;
        autoMode = 0; stepBtn = 0;
        start = 1; count = 2; tick(); start = 0;
        wait_phase("man_show0", 0, 50);
        repeat (1000) tick();
        chk("man_hold_idx", 32'(index), 32'd0);
        chk("man_hold_led", ledData, 32'hA5A5_0001);
        chk("man_hold_done", 32'(done), 32'd0);
        stepBtn = 1; tick(); stepBtn = 0;
        wait_phase("man_wait1", 1, 50);
        stepBtn = 1; repeat (6) tick();
        chk("man_wait_press_idx", 32'(index), 32'd1);
        chk("man_wait_press_done", 32'(done), 32'd0);
        stepBtn = 0; tick(); stepBtn = 1; tick(); stepBtn = 0; tick();
        chk("man_done", 32'(done), 32'd1);
        chk("man_done_idx", 32'(index), 32'd1);

        // mode toggle mid-dwell, then step edge on dwell expiry
        for (int i = 0; i < 3; i++) mem[i] = 32'h5000 + 32'(i);
        clear_obs(); autoMode = 1;
        start = 1; count = 3; tick(); start = 0;
        wait_phase("tog_show0", 0, 50);
        tick();
        autoMode = 0; repeat (10) tick(); autoMode = 1;
        wait_phase("tog_show1", 2, 100);
        stepBtn = 1; tick(); stepBtn = 0;
        run_until_idle("toggle", 200);
        chk("tog_hold0", (holds.size() > 0) ? 32'(holds[0]) : 32'hDEAD, 32'd14);
        chk("tog_hold1", (holds.size() > 1) ? 32'(holds[1]) : 32'hDEAD, 32'd4);
        chk("tog_nfetch", 32'(addrs.size()), 32'd3);
        chk("tog_idx", 32'(index), 32'd2);

        // reset while a request is outstanding
        clear_obs(); gdelay = 10;
        start = 1; count = 3; tick(); start = 0;
        rst = 1; memGrant = 1; tick(); rst = 0;
        chk("rst_memReq", 32'(memReq), 32'd0);
        chk("rst_memAddr", memAddr, 32'd0);
        chk("rst_ledValid", 32'(ledValid), 32'd0);
        chk("rst_ledData", ledData, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        clear_obs(); gdelay = 0;
        start = 1; count = 2; tick(); start = 0;
        run_until_idle("rst_restart", 200);
        chk("rst_first_addr", (addrs.size() > 0) ? addrs[0] : 32'hDEAD, 32'h100);

        // count above 16 bits saturates rather than truncating
        start = 1; count = 32'h0001_0003; tick(); start = 0;
        repeat (60) tick();
        chk("sat_done", 32'(done), 32'd0);
        chk("sat_busy", 32'(busy), 32'd1);
        rst = 1; tick(); rst = 0; tick();

        // random runs
        noise = 1; gdelay_rand = 1; btn_rand = 1;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 8; i++) mem[i] = $urandom;
            autoMode = 1'($urandom_range(0, 1)); stepBtn = 0;
            start = 1; count = $urandom_range(0, 6); tick(); start = 0;
            for (int n = 0; n < 400 && !model_idle(); n++) begin
                start = ($urandom_range(0, 15) == 0);
                count = $urandom_range(0, 6);
                rst = ($urandom_range(0, 249) == 0);
                if ($urandom_range(0, 39) == 0) begin
                    autoMode = !autoMode;
                    if (autoMode) stepBtn = 0;
                end
                tick();
            end
            start = 0; rst = 0;
            if (!model_idle()) begin
                vectors++; miscompares++;
                $display("FAIL random_run: run %0d still busy, required idle", r);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/result_view_ctrl.md
# result_view_ctrl

Sequencer that replays the sorted array on the 7-segment display once the sort program reports completion. Triggered by the sort-finish strobe, it walks data memory from a base address for the reported element count, fetching each word over a request/grant port shared with the CPU data-memory path. It holds each value on the LED input bus either for a fixed dwell time or until a manual step press. It sits between the IO controller, which supplies the finish strobe and count and consumes the LED data, and the data-memory arbiter.

## Interface
- DATA_WIDTH, 32, data word and LED bus width (8 nibbles)
- ADDR_WIDTH, 32, data-memory byte address width
- BASE_ADDR, 0, byte address of element 0
- WORD_BYTES, 4, address stride per element
- DWELL_CYCLES, 50_000_000, cycles each value is shown in auto mode (>=1)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  sort-finish strobe, level-sampled
- count  in  DATA_WIDTH  element count, latched on accepted start
- autoMode  in  1  1 = dwell-timed advance, 0 = manual step
- stepBtn  in  1  debounced step button, active-high level
- memReq  out  1  read request to data-memory arbiter
- memAddr  out  ADDR_WIDTH  byte address of the request
- memGrant  in  1  arbiter grant for the current request
- memData  in  DATA_WIDTH  read data, valid the cycle after grant
- ledData  out  DATA_WIDTH  value for the LED registers
- ledValid  out  1  ledData holds a fetched element
- index  out  16  index of the displayed element
- busy  out  1  sequence in progress
- done  out  1  sequence complete

## Operation
- States: IDLE, REQ, WAIT, SHOW, DONE.
- IDLE:
  - start=1 and count!=0: latch count, saturated to 65535 (cnt). idx=0. Go to REQ.
  - start=1 and count==0: go to DONE. ledValid stays 0.
- REQ: memReq=1. memAddr = BASE_ADDR + idx*WORD_BYTES, modulo 2^ADDR_WIDTH. memGrant=1 goes to WAIT.
- WAIT: capture memData into ledData, set ledValid=1, index=idx. Load the dwell counter with DWELL_CYCLES-1. Go to SHOW.
- SHOW: the advance event depends on autoMode:
  - autoMode=1: dwell counter reaches 0.
  - autoMode=0: rising edge of stepBtn, detected on stepBtn registered vs current.
  - If both occur in the same cycle, exactly one advance.
  - On advance: if idx+1==cnt, go to DONE; otherwise idx=idx+1 and go to REQ.
  - autoMode is sampled every cycle. Switching to manual freezes the counter. Switching back resumes from the frozen value.
- DONE: done=1. ledData and ledValid hold the last element. start=1 restarts exactly as from IDLE (count re-latched).
- start is ignored in REQ, WAIT and SHOW.
- busy=1 in REQ, WAIT and SHOW.
- The stepBtn edge detector runs in all states. An edge outside SHOW is discarded.

## Timing
- Reset values: memReq=0, memAddr=0, ledData=0, ledValid=0, index=0, busy=0, done=0, state=IDLE, stepBtn history=0.
- Reset mid-fetch: memReq drops on the first edge with rst=1. An outstanding grant is ignored.
- Start to request: start sampled at edge k; memReq=1 from edge k+1.
- memReq and memAddr are registered and stable from request to grant. memReq deasserts at the edge that samples memGrant=1.
- Grant to display: grant sampled at edge g; WAIT during cycle g..g+1; ledData, ledValid and index update at edge g+1.
- Auto mode: ledData for element i is held exactly DWELL_CYCLES cycles in SHOW. memReq for element i+1 rises at the edge ending SHOW.
- Manual mode: stepBtn rising between edges s-1 and s is detected at edge s; the next memReq rises at edge s.
- No combinational path from inputs to outputs.

## Test plan
- Auto sequence (DWELL_CYCLES=4, BASE_ADDR=0x100): count=3, memory 0x11,0x22,0x33, grant one cycle after each request. Required: addresses 0x100, 0x104, 0x108; each value shown 4 cycles; done=1 and ledData=0x33 afterwards.
- Delayed grant: memGrant held low for 5 cycles. Required: memReq and memAddr stable for all 6 cycles, a single fetch, ledData updates one edge after the grant.
- Manual stepping (autoMode=0, count=2): no press leaves the display held for 1000 cycles; one press advances to index=1; a second press sets done=1. A press while in WAIT is discarded.
- count=0 start: DONE next cycle, memReq never asserted, ledValid=0. Start while busy: ignored, count not re-latched.
- Reset mid-operation: rst=1 during REQ. Required: memReq=0 on the next edge, all outputs at reset values, a following start begins at index 0.
- Mode toggle and coincident events: auto to manual mid-dwell freezes the counter, and back resumes. A step edge on the dwell-expiry cycle advances exactly one index.
